// File: rtl/dma_seq_pkg.sv
// Shared types for the DMA channel sequencer: one-hot timing states, transfer
// direction, per-channel mode record and a one-hot to index helper.
package dma_seq_pkg;

    localparam int MAX_CH = 8;

    typedef enum logic [5:0] {
        SI = 6'b000001,
        S0 = 6'b000010,
        S1 = 6'b000100,
        S2 = 6'b001000,
        S3 = 6'b010000,
        S4 = 6'b100000
    } dma_state_e;

    typedef enum logic {
        DIR_WRITE = 1'b0,
        DIR_READ  = 1'b1
    } dma_dir_e;

    typedef struct packed {
        dma_dir_e dir;
        logic     dec;
        logic     autoinit;
        logic     demand;
        logic     armed;
    } dma_ch_mode_t;

    function automatic int onehot_to_idx(input logic [MAX_CH-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_CH; i++) begin
            idx = oh[i] ? i : idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/dma_chan_sequencer_arbiter.sv
// Channel priority arbiter: fixed (lowest index wins) or rotating priority,
// owning the rotation pointer that names the current highest-priority channel.
module dma_priority_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         req,
    input  logic                      rot_pri,
    input  logic                      rotate,
    input  logic [$clog2(NUM_CH)-1:0] svc_idx,
    output logic [NUM_CH-1:0]         grant
);

    localparam int CH_W = $clog2(NUM_CH);

    logic [CH_W-1:0] ptr_r;
    int              start_s;
    int              idx_s;
    logic            found_s;

    // Rotation pointer: the channel after the one just serviced becomes highest priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= '0;
        end else if (rotate) begin
            if (svc_idx == CH_W'(NUM_CH - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= svc_idx + CH_W'(1'b1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Grant search starting from channel 0 (fixed) or from the pointer (rotating).
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        idx_s   = 0;
        start_s = rot_pri ? int'(ptr_r) : 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx_s = (start_s + k) % NUM_CH;
            if (!found_s && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/dma_chan_sequencer.sv
// DMA transfer sequencer: HRQ/HLDA handshake, one-hot SI..S4 timing, address and
// count update, autoinit and terminal count. Optional DMA_DEMAND_MODE_EN keeps a demand channel looping.
module dma_chan_sequencer
    import dma_seq_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      CS_N,
    input  logic [NUM_CH-1:0]         DREQ,
    input  logic                      HLDA,
    input  logic                      cfg_wr,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [ADDR_W-1:0]         cfg_addr,
    input  logic [CNT_W-1:0]          cfg_count,
    input  logic                      cfg_dir,
    input  logic                      cfg_dec,
    input  logic                      cfg_autoinit,
    input  logic                      cfg_demand,
    input  logic                      rot_pri,
    output logic                      HRQ,
    output logic [NUM_CH-1:0]         DACK,
    output logic                      AEN,
    output logic                      ADSTB,
    output logic [ADDR_W-1:0]         ADDR,
    output logic                      MEMR_N,
    output logic                      MEMW_N,
    output logic                      IOR_N,
    output logic                      IOW_N,
    output logic                      EOP_N,
    output logic [NUM_CH-1:0]         tc_status
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
    localparam logic [NUM_CH-1:0] CH_ONE   = NUM_CH'(1'b1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [CNT_W-1:0]  count;
        dma_ch_mode_t      mode;
    } dma_ch_cfg_t;

    dma_state_e        state_r;
    dma_state_e        next_state_s;
    dma_ch_cfg_t       cur_r [NUM_CH];
    logic [ADDR_W-1:0] base_addr_r [NUM_CH];
    logic [CNT_W-1:0]  base_count_r [NUM_CH];
    logic [CH_W-1:0]   gnt_r;
    logic [CH_W-1:0]   gnt_nxt_s;
    logic [CH_W-1:0]   arb_idx_s;
    logic [NUM_CH-1:0] arb_gnt_s;
    logic [NUM_CH-1:0] armed_s;
    logic [NUM_CH-1:0] qual_s;
    logic              latch_s;
    logic              complete_s;
    logic              tc_s;
    logic              cfg_ok_s;
    logic              demand_loop_s;
    logic [ADDR_W-1:0] upd_addr_s;
    logic [CNT_W-1:0]  upd_count_s;
    logic              hrq_s;
    logic              aen_s;
    logic              adstb_s;
    logic              rd_s;
    logic              wr_s;
    logic              is_read_s;
    logic [NUM_CH-1:0] dack_s;
    logic [ADDR_W-1:0] addr_s;
    logic              eop_s;

    // Qualified requests only come from armed channels.
    always_comb begin
        armed_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            armed_s[i] = cur_r[i].mode.armed;
        end
        qual_s = DREQ & armed_s;
    end

    dma_priority_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk     (CLK),
        .reset   (RESET),
        .req     (qual_s),
        .rot_pri (rot_pri),
        .rotate  (complete_s && rot_pri),
        .svc_idx (gnt_r),
        .grant   (arb_gnt_s)
    );

    assign arb_idx_s = CH_W'(onehot_to_idx(MAX_CH'(arb_gnt_s)));
    assign gnt_nxt_s = latch_s ? arb_idx_s : gnt_r;

    assign tc_s        = (cur_r[gnt_r].count == '0);
    assign upd_addr_s  = cur_r[gnt_r].mode.dec ? (cur_r[gnt_r].addr - ADDR_ONE)
                                               : (cur_r[gnt_r].addr + ADDR_ONE);
    assign upd_count_s = cur_r[gnt_r].count - CNT_ONE;
    // A config write to the channel that owns the bus is dropped until it is back in SI.
    assign cfg_ok_s    = cfg_wr && ((state_r == SI) || (cfg_ch != gnt_r));

`ifdef DMA_DEMAND_MODE_EN
    assign demand_loop_s = cur_r[gnt_r].mode.demand && DREQ[gnt_r] && !tc_s;
`else
    logic unused_demand_s;

    // Demand bits are stored but have no effect in single-transfer builds.
    always_comb begin
        unused_demand_s = cfg_demand;
        for (int i = 0; i < NUM_CH; i++) begin
            unused_demand_s = unused_demand_s | cur_r[i].mode.demand;
        end
    end

    assign demand_loop_s = 1'b0;
`endif

    // Next-state logic; HLDA loss anywhere in S1..S4 aborts without touching counters.
    always_comb begin
        next_state_s = state_r;
        latch_s      = 1'b0;
        complete_s   = 1'b0;
        case (state_r)
            SI: begin
                if (!CS_N && (|qual_s)) begin
                    next_state_s = S0;
                    latch_s      = 1'b1;
                end else begin
                    next_state_s = SI;
                end
            end
            S0: begin
                if (!qual_s[gnt_r]) begin
                    next_state_s = SI;
                end else if (HLDA) begin
                    next_state_s = S1;
                end else begin
                    next_state_s = S0;
                end
            end
            S1: next_state_s = HLDA ? S2 : SI;
            S2: next_state_s = HLDA ? S3 : SI;
            S3: next_state_s = HLDA ? S4 : SI;
            S4: begin
                if (HLDA) begin
                    complete_s   = 1'b1;
                    next_state_s = demand_loop_s ? S1 : SI;
                end else begin
                    next_state_s = SI;
                end
            end
            default: next_state_s = SI;
        endcase
    end

    // Output values for the state being entered, so every pin is registered.
    always_comb begin
        hrq_s     = (next_state_s != SI);
        aen_s     = (next_state_s inside {S1, S2, S3, S4});
        adstb_s   = (next_state_s == S1);
        rd_s      = (next_state_s inside {S2, S3, S4});
        wr_s      = (next_state_s inside {S3, S4});
        is_read_s = (cur_r[gnt_nxt_s].mode.dir == DIR_READ);
        eop_s     = (next_state_s == S4) && (cur_r[gnt_nxt_s].count == '0);
        if (aen_s) begin
            dack_s = CH_ONE << gnt_nxt_s;
        end else begin
            dack_s = '0;
        end
        // A demand loop re-enters S1 straight from S4, so use the freshly stepped address.
        if (adstb_s) begin
            if (state_r == S4) begin
                addr_s = upd_addr_s;
            end else begin
                addr_s = cur_r[gnt_nxt_s].addr;
            end
        end else if (aen_s) begin
            addr_s = ADDR;
        end else begin
            addr_s = '0;
        end
    end

    // State, grant and bus outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= SI;
            gnt_r   <= '0;
            HRQ     <= 1'b0;
            DACK    <= '0;
            AEN     <= 1'b0;
            ADSTB   <= 1'b0;
            ADDR    <= '0;
            MEMR_N  <= 1'b1;
            MEMW_N  <= 1'b1;
            IOR_N   <= 1'b1;
            IOW_N   <= 1'b1;
            EOP_N   <= 1'b1;
        end else begin
            state_r <= next_state_s;
            gnt_r   <= gnt_nxt_s;
            HRQ     <= hrq_s;
            DACK    <= dack_s;
            AEN     <= aen_s;
            ADSTB   <= adstb_s;
            ADDR    <= addr_s;
            MEMR_N  <= !(rd_s && is_read_s);
            IOR_N   <= !(rd_s && !is_read_s);
            IOW_N   <= !(wr_s && is_read_s);
            MEMW_N  <= !(wr_s && !is_read_s);
            EOP_N   <= !eop_s;
        end
    end

    // Channel registers; the config write is applied last so it beats a same-cycle TC reload.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cur_r[i]        <= '0;
                base_addr_r[i]  <= '0;
                base_count_r[i] <= '0;
            end
        end else begin
            if (complete_s) begin
                if (tc_s && cur_r[gnt_r].mode.autoinit) begin
                    cur_r[gnt_r].addr  <= base_addr_r[gnt_r];
                    cur_r[gnt_r].count <= base_count_r[gnt_r];
                end else begin
                    cur_r[gnt_r].addr  <= upd_addr_s;
                    cur_r[gnt_r].count <= upd_count_s;
                    if (tc_s) begin
                        cur_r[gnt_r].mode.armed <= 1'b0;
                    end else begin
                        cur_r[gnt_r].mode.armed <= cur_r[gnt_r].mode.armed;
                    end
                end
            end
            if (cfg_ok_s) begin
                cur_r[cfg_ch].addr          <= cfg_addr;
                cur_r[cfg_ch].count         <= cfg_count;
                cur_r[cfg_ch].mode.dir      <= dma_dir_e'(cfg_dir);
                cur_r[cfg_ch].mode.dec      <= cfg_dec;
                cur_r[cfg_ch].mode.autoinit <= cfg_autoinit;
                cur_r[cfg_ch].mode.demand   <= cfg_demand;
                cur_r[cfg_ch].mode.armed    <= 1'b1;
                base_addr_r[cfg_ch]         <= cfg_addr;
                base_count_r[cfg_ch]        <= cfg_count;
            end
        end
    end

    // Sticky terminal-count flags, set when a TC transfer completes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tc_status <= '0;
        end else begin
            if (complete_s && tc_s) begin
                tc_status[gnt_r] <= 1'b1;
            end
            if (cfg_ok_s) begin
                tc_status[cfg_ch] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dma_chan_sequencer.sv
// Directed bench for dma_chan_sequencer with hand-computed expectations.
// The demand-mode section follows DMA_DEMAND_MODE_EN.
module tb_dma_chan_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CS_N;
    logic [3:0]  DREQ;
    logic        HLDA;
    logic        cfg_wr;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_addr;
    logic [15:0] cfg_count;
    logic        cfg_dir;
    logic        cfg_dec;
    logic        cfg_autoinit;
    logic        cfg_demand;
    logic        rot_pri;
    logic        HRQ;
    logic [3:0]  DACK;
    logic        AEN;
    logic        ADSTB;
    logic [15:0] ADDR;
    logic        MEMR_N;
    logic        MEMW_N;
    logic        IOR_N;
    logic        IOW_N;
    logic        EOP_N;
    logic [3:0]  tc_status;

    int n_total = 0;
    int n_bad   = 0;

    dma_chan_sequencer #(.NUM_CH(4), .ADDR_W(16), .CNT_W(16)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .CS_N         (CS_N),
        .DREQ         (DREQ),
        .HLDA         (HLDA),
        .cfg_wr       (cfg_wr),
        .cfg_ch       (cfg_ch),
        .cfg_addr     (cfg_addr),
        .cfg_count    (cfg_count),
        .cfg_dir      (cfg_dir),
        .cfg_dec      (cfg_dec),
        .cfg_autoinit (cfg_autoinit),
        .cfg_demand   (cfg_demand),
        .rot_pri      (rot_pri),
        .HRQ          (HRQ),
        .DACK         (DACK),
        .AEN          (AEN),
        .ADSTB        (ADSTB),
        .ADDR         (ADDR),
        .MEMR_N       (MEMR_N),
        .MEMW_N       (MEMW_N),
        .IOR_N        (IOR_N),
        .IOW_N        (IOW_N),
        .EOP_N        (EOP_N),
        .tc_status    (tc_status)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    function automatic logic [3:0] strobes();
        return {MEMR_N, MEMW_N, IOR_N, IOW_N};
    endfunction

    task automatic do_cfg(input int ch, input logic [15:0] a, input logic [15:0] c,
                          input logic dir, input logic dec, input logic ai, input logic dm);
        cfg_ch       = 2'(ch);
        cfg_addr     = a;
        cfg_count    = c;
        cfg_dir      = dir;
        cfg_dec      = dec;
        cfg_autoinit = ai;
        cfg_demand   = dm;
        cfg_wr       = 1'b1;
        step(1);
        cfg_wr       = 1'b0;
    endtask

    task automatic wait_s1(input string tag);
        int n;
        n = 0;
        while (ADSTB !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        check(tag, 32'(ADSTB), 32'h1);
    endtask

    task automatic pulse_reset();
        RESET = 1'b1;
        step(2);
        RESET = 1'b0;
    endtask

    logic [3:0] exp_rot [4];
    int         gap;
    int         pulses;

    initial begin
        exp_rot = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};
        RESET = 1'b1; CS_N = 1'b0; DREQ = 4'b0000; HLDA = 1'b1; cfg_wr = 1'b0;
        cfg_ch = 2'd0; cfg_addr = 16'h0000; cfg_count = 16'h0000; cfg_dir = 1'b0;
        cfg_dec = 1'b0; cfg_autoinit = 1'b0; cfg_demand = 1'b0; rot_pri = 1'b0;
        step(3);
        RESET = 1'b0;

        check("rst_hrq", 32'(HRQ), 32'h0);
        check("rst_dack", 32'(DACK), 32'h0);
        check("rst_strobes", 32'(strobes()), 32'hF);
        check("rst_eop", 32'(EOP_N), 32'h1);
        check("rst_addr", 32'(ADDR), 32'h0);
        check("rst_tc", 32'(tc_status), 32'h0);

        // Two read transfers on ch1, second one hits terminal count.
        do_cfg(1, 16'h1000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
        DREQ = 4'b0010;
        step(1);
        check("hrq_latency", 32'(HRQ), 32'h1);
        check("s0_aen", 32'(AEN), 32'h0);
        step(1);
        check("s1_adstb", 32'(ADSTB), 32'h1);
        check("s1_addr0", 32'(ADDR), 32'h1000);
        check("s1_dack", 32'(DACK), 32'h2);
        step(1);
        check("s2_strobes", 32'(strobes()), 32'h7);
        check("s2_adstb", 32'(ADSTB), 32'h0);
        step(1);
        check("s3_strobes", 32'(strobes()), 32'h6);
        step(1);
        check("s4_eop_no_tc", 32'(EOP_N), 32'h1);
        step(1);
        check("si_hrq", 32'(HRQ), 32'h0);
        check("si_strobes", 32'(strobes()), 32'hF);
        wait_s1("xfer2_start");
        check("s1_addr1", 32'(ADDR), 32'h1001);
        step(3);
        check("tc_eop", 32'(EOP_N), 32'h0);
        check("tc_s4_strobes", 32'(strobes()), 32'h6);
        step(1);
        check("tc_status_ch1", 32'(tc_status), 32'h2);
        check("tc_eop_released", 32'(EOP_N), 32'h1);
        step(4);
        check("disarmed_no_hrq", 32'(HRQ), 32'h0);
        DREQ = 4'b0000;

        // Reset in the middle of a write transfer on ch2.
        do_cfg(2, 16'h2000, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
        DREQ = 4'b0100;
        wait_s1("ch2_start");
        step(2);
        check("s3_write_strobes", 32'(strobes()), 32'h9);
        RESET = 1'b1;
        step(1);
        RESET = 1'b0;
        DREQ  = 4'b0000;
        check("midrst_state", 32'(dut.state_r), 32'h1);
        check("midrst_strobes", 32'(strobes()), 32'hF);
        check("midrst_hrq", 32'(HRQ), 32'h0);
        check("midrst_dack", 32'(DACK), 32'h0);
        check("midrst_tc", 32'(tc_status), 32'h0);

        // Fixed priority: ch1 always wins over ch2/ch3.
        for (int ch = 0; ch < 4; ch++) begin
            do_cfg(ch, 16'h4000 + 16'(ch * 256), 16'h00FF, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        DREQ = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            wait_s1("fixed_start");
            check("fixed_dack", 32'(DACK), 32'h2);
            step(4);
        end
        DREQ = 4'b0000;

        // Rotating priority from a fresh pointer.
        pulse_reset();
        for (int ch = 0; ch < 4; ch++) begin
            do_cfg(ch, 16'h4000 + 16'(ch * 256), 16'h00FF, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        rot_pri = 1'b1;
        DREQ    = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            wait_s1("rot_start");
            check("rot_dack", 32'(DACK), 32'(exp_rot[k]));
            step(4);
        end
        DREQ    = 4'b0000;
        rot_pri = 1'b0;

        // Decrementing autoinit channel with a single transfer per block.
        do_cfg(0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
        DREQ = 4'b0001;
        wait_s1("ai_start");
        check("ai_addr", 32'(ADDR), 32'h0);
        step(3);
        check("ai_eop", 32'(EOP_N), 32'h0);
        step(1);
        check("ai_tc", 32'(tc_status), 32'h1);
        wait_s1("ai_rearmed");
        check("ai_reload_addr", 32'(ADDR), 32'h0);
        step(4);
        DREQ = 4'b0000;

        // HLDA lost in S2, then a request dropped while waiting in S0.
        do_cfg(3, 16'h3000, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
        DREQ = 4'b1000;
        wait_s1("abort_start");
        step(1);
        HLDA = 1'b0;
        step(1);
        check("abort_state", 32'(dut.state_r), 32'h1);
        check("abort_hrq", 32'(HRQ), 32'h0);
        check("abort_strobes", 32'(strobes()), 32'hF);
        check("abort_eop", 32'(EOP_N), 32'h1);
        step(2);
        check("s0_wait_hrq", 32'(HRQ), 32'h1);
        check("s0_wait_adstb", 32'(ADSTB), 32'h0);
        DREQ = 4'b0000;
        step(1);
        check("s0_drop_hrq", 32'(HRQ), 32'h0);
        DREQ = 4'b1000;
        HLDA = 1'b1;
        wait_s1("abort_retry");
        check("abort_addr_kept", 32'(ADDR), 32'h3000);
        step(3);
        check("abort_retry_eop", 32'(EOP_N), 32'h1);
        step(1);
        check("abort_retry_tc", 32'(tc_status), 32'h1);
        DREQ = 4'b0000;

        // Demand channel with count 3 and DREQ held.
        do_cfg(2, 16'h5000, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b1);
        DREQ = 4'b0100;
        wait_s1("dm_start");
        check("dm_addr0", 32'(ADDR), 32'h5000);
`ifdef DMA_DEMAND_MODE_EN
        gap    = 0;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            step(1);
            if (HRQ !== 1'b1) gap++;
            if (ADSTB === 1'b1) pulses++;
        end
        check("dm_hrq_gap", 32'(gap), 32'h0);
        check("dm_pulses", 32'(pulses), 32'h3);
        check("dm_last_addr", 32'(ADDR), 32'h5003);
        check("dm_eop", 32'(EOP_N), 32'h0);
        step(1);
        check("dm_exit_hrq", 32'(HRQ), 32'h0);
        check("dm_tc", 32'(tc_status), 32'h5);
`else
        step(3);
        check("single_eop", 32'(EOP_N), 32'h1);
        step(1);
        check("single_exit_hrq", 32'(HRQ), 32'h0);
`endif
        DREQ = 4'b0000;
        step(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
